// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan controller.
package seven_seg_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    typedef enum logic {
        SCAN_BLANK,
        SCAN_SHOW
    } scan_state_e;

    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] index);
        logic [MAX_DIGITS-1:0] vec;
        vec        = '0;
        vec[index] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Per-slot cycle counter for the digit scan; frozen while ena is low.
module scan_tick_gen
    import seven_seg_pkg::*;
#(
    parameter int TICK_DIV     = 1024,
    parameter int BLANK_CYCLES = 16,
    localparam int CNT_W       = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    output logic [CNT_W-1:0] cnt,
    output logic             show_start,
    output logic             slot_end
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ena) begin
            if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt        = cnt_q;
    assign show_start = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
    assign slot_end   = (cnt_q == CNT_W'(TICK_DIV - 1));

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS digits over one code bus, with a
// frame-synchronous double buffer and leading-zero blanking.
//
//   state      | meaning
//   SCAN_BLANK | dark gap at the start of a slot, no digit enabled
//   SCAN_SHOW  | current digit driven for the rest of the slot
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]         load_dp,
    input  logic                          lzb_en,
    output logic [DIGIT_W-1:0]            digit_bin,
    output logic                          digit_dp,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          blank,
    output logic                          frame_done
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int DATA_W = DIGIT_W * NUM_DIGITS;

    scan_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] active_data_q, active_data_d;
    logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic              pend_full_q, pend_full_d;
    logic              lzb_q, lzb_d;

    logic [CNT_W-1:0]  slot_cnt;
    logic              show_start;
    logic              slot_end;
    logic              frame_end;
    logic [NUM_DIGITS-1:0] lz_sup;
    logic              zero_above;

    scan_tick_gen #(
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .cnt        (slot_cnt),
        .show_start (show_start),
        .slot_end   (slot_end)
    );

    assign frame_end = (state_q == SCAN_SHOW) && slot_end
                       && (idx_q == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        active_data_d = active_data_q;
        active_dp_d   = active_dp_q;
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        pend_full_d   = pend_full_q;
        lzb_d         = lzb_q;

        if (ena) begin
            lzb_d = lzb_en;
            case (state_q)
                SCAN_BLANK: if (show_start) state_d = SCAN_SHOW;
                SCAN_SHOW:  if (slot_end)   state_d = SCAN_BLANK;
                default:                    state_d = SCAN_BLANK;
            endcase
            if (slot_end) begin
                if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            if (frame_end && pend_full_q) begin
                active_data_d = pend_data_q;
                active_dp_d   = pend_dp_q;
                pend_full_d   = 1'b0;
            end
        end

        // Loading requires an empty buffer, so it can never overlap a commit.
        if (load_valid && !pend_full_q) begin
            pend_data_d = load_data;
            pend_dp_d   = load_dp;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SCAN_BLANK;
            idx_q         <= '0;
            active_data_q <= '0;
            active_dp_q   <= '0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_full_q   <= 1'b0;
            lzb_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            active_data_q <= active_data_d;
            active_dp_q   <= active_dp_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_full_q   <= pend_full_d;
            lzb_q         <= lzb_d;
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        lz_sup     = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (active_data_q[i*DIGIT_W +: DIGIT_W] == '0);
            lz_sup[i]  = (i > 0) && lzb_q && zero_above && !active_dp_q[i];
        end
    end

    always_comb begin
        digit_en  = '0;
        blank     = 1'b1;
        digit_bin = '0;
        digit_dp  = 1'b0;
        if (state_q == SCAN_SHOW) begin
            digit_bin = active_data_q[idx_q*DIGIT_W +: DIGIT_W];
            digit_dp  = active_dp_q[idx_q];
            if (!lz_sup[idx_q]) begin
                digit_en = NUM_DIGITS'(onehot(3'(idx_q)));
                blank    = 1'b0;
            end
        end
    end

    assign load_ready = !pend_full_q;
    // Derived from held state, so it stays high if the scan freezes on the boundary.
    assign frame_done = frame_end;

    show_after_gap: assert property (@(posedge clk) disable iff (rst)
        (state_q == SCAN_SHOW) |-> (slot_cnt >= CNT_W'(BLANK_CYCLES)));

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: scan-time model checked every cycle plus literal pins.
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int TD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * TD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic        load_valid = 1'b0;
    logic        lzb_en = 1'b0;
    logic [15:0] load_data = '0;
    logic [3:0]  load_dp = '0;
    logic        load_ready;
    logic [3:0]  digit_bin;
    logic        digit_dp;
    logic [3:0]  digit_en;
    logic        blank;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          m_t;
    bit          m_valid = 1'b0;
    logic        m_full;
    logic        m_lzb;
    logic [15:0] m_pend, m_act;
    logic [3:0]  m_pend_dp, m_act_dp;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .TICK_DIV     (TD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .lzb_en     (lzb_en),
        .digit_bin  (digit_bin),
        .digit_dp   (digit_dp),
        .digit_en   (digit_en),
        .blank      (blank),
        .frame_done (frame_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Model: m_t is elapsed scan time; slot, digit and lit phase follow by arithmetic.
    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_full = 1'b0; m_lzb = 1'b0;
            m_act = '0; m_act_dp = '0; m_pend = '0; m_pend_dp = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_full) begin
                if (ena && (m_t % FRAME == FRAME - 1)) begin
                    m_act = m_pend; m_act_dp = m_pend_dp; m_full = 1'b0;
                end
            end else if (load_valid) begin
                m_pend = load_data; m_pend_dp = load_dp; m_full = 1'b1;
            end
            if (ena) begin
                m_t++;
                m_lzb = lzb_en;
            end
        end
    end

    always @(negedge clk) begin
        int pos, d;
        bit lit, sup;
        logic [15:0] upper;
        int e_en, e_bin, e_dp;
        if (m_valid) begin
            pos   = m_t % FRAME;
            d     = pos / TD;
            lit   = (pos % TD) >= BC;
            upper = m_act >> (4 * d);
            sup   = m_lzb && (d > 0) && (upper == 16'h0) && !m_act_dp[d];
            e_en  = (lit && !sup) ? (1 << d) : 0;
            e_bin = lit ? int'(upper[3:0]) : 0;
            e_dp  = lit ? int'(m_act_dp[d]) : 0;
            chk("model digit_en",   int'(digit_en),   e_en);
            chk("model blank",      int'(blank),      (e_en == 0) ? 1 : 0);
            chk("model digit_bin",  int'(digit_bin),  e_bin);
            chk("model digit_dp",   int'(digit_dp),   e_dp);
            chk("model frame_done", int'(frame_done), (pos == FRAME - 1) ? 1 : 0);
            chk("model load_ready", int'(load_ready), m_full ? 0 : 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_valid = 1'b0;
        ena = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic load(input logic [15:0] data, input logic [3:0] dp);
        load_data  = data;
        load_dp    = dp;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: plain scan, no loads
        do_reset();
        chk("s1 en c0", int'(digit_en), 0);
        chk("s1 blank c0", int'(blank), 1);
        goto(1);  chk("s1 en c1", int'(digit_en), 0);
        goto(2);  chk("s1 en c2", int'(digit_en), 1);
        chk("s1 bin c2", int'(digit_bin), 0);
        goto(7);  chk("s1 en c7", int'(digit_en), 1);
        goto(8);  chk("s1 en c8", int'(digit_en), 0);
        goto(10); chk("s1 en c10", int'(digit_en), 2);
        goto(30); chk("s1 fd c30", int'(frame_done), 0);
        goto(31); chk("s1 fd c31", int'(frame_done), 1);
        goto(32); chk("s1 fd c32", int'(frame_done), 0);
        goto(63); chk("s1 fd c63", int'(frame_done), 1);

        // 2: single load, committed at the frame boundary
        do_reset();
        goto(3);  load(16'h1234, 4'b0000);
        chk("s2 ready c4", int'(load_ready), 0);
        goto(31); chk("s2 ready c31", int'(load_ready), 0);
        goto(32); chk("s2 ready c32", int'(load_ready), 1);
        goto(34); chk("s2 bin c34", int'(digit_bin), 4);
        chk("s2 en c34", int'(digit_en), 1);
        goto(42); chk("s2 bin c42", int'(digit_bin), 3);
        goto(50); chk("s2 bin c50", int'(digit_bin), 2);
        goto(58); chk("s2 bin c58", int'(digit_bin), 1);
        chk("s2 en c58", int'(digit_en), 8);

        // 3: held valid, second transfer one cycle after the commit
        do_reset();
        load_data = 16'hAAAA; load_valid = 1'b1;
        step();
        load_data = 16'h5555;
        goto(31); chk("s3 ready c31", int'(load_ready), 0);
        goto(32); chk("s3 ready c32", int'(load_ready), 1);
        step();
        chk("s3 ready c33", int'(load_ready), 0);
        load_valid = 1'b0;
        goto(34); chk("s3 bin c34", int'(digit_bin), 4'hA);
        goto(58); chk("s3 bin c58", int'(digit_bin), 4'hA);
        goto(66); chk("s3 bin c66", int'(digit_bin), 4'h5);

        // 4: leading-zero blanking
        lzb_en = 1'b1;
        do_reset();
        goto(3);  load(16'h0050, 4'b0000);
        goto(34); chk("s4 en d0", int'(digit_en), 1);
        chk("s4 bin d0", int'(digit_bin), 0);
        goto(40); load(16'h0050, 4'b1000);
        goto(42); chk("s4 en d1", int'(digit_en), 2);
        chk("s4 bin d1", int'(digit_bin), 5);
        goto(50); chk("s4 en d2", int'(digit_en), 0);
        chk("s4 blank d2", int'(blank), 1);
        goto(58); chk("s4 en d3", int'(digit_en), 0);
        goto(82); chk("s4 en d2 dp", int'(digit_en), 0);
        goto(90); chk("s4 en d3 dp", int'(digit_en), 8);
        chk("s4 bin d3 dp", int'(digit_bin), 0);
        chk("s4 dp d3 dp", int'(digit_dp), 1);
        lzb_en = 1'b0;

        // 5: ena freeze
        do_reset();
        goto(4);  ena = 1'b0;
        goto(6);  chk("s5 en c6", int'(digit_en), 1);
        goto(9);  ena = 1'b1;
        goto(12); chk("s5 en c12", int'(digit_en), 1);
        goto(13); chk("s5 en c13", int'(digit_en), 0);
        goto(31); chk("s5 fd c31", int'(frame_done), 0);
        goto(36); chk("s5 fd c36", int'(frame_done), 1);

        // 6: reset mid-frame drops the pending value
        do_reset();
        goto(3);  load(16'h1234, 4'b1111);
        goto(20); rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s6 en", int'(digit_en), 0);
        chk("s6 blank", int'(blank), 1);
        chk("s6 ready", int'(load_ready), 1);
        chk("s6 fd", int'(frame_done), 0);
        cyc = 0;
        goto(34); chk("s6 bin c34", int'(digit_bin), 0);
        chk("s6 en c34", int'(digit_en), 1);
        goto(58); chk("s6 bin c58", int'(digit_bin), 0);
        chk("s6 dp c58", int'(digit_dp), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
